window_3x3_linebuffer: RTL and testbench

WINDOW_3X3_LINEBUFFER -- requirements
Module: window_3x3_linebuffer

---
 rtl/window_3x3_linebuffer.sv | 99 +++++++++
 tb/tb_window_3x3_linebuffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_linebuffer.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Emits one window per accepted pixel at row>=2, col>=2 with ready/valid on both sides.
module window_3x3_linebuffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       in_ready,
  output logic [7:0] win_0,
  output logic [7:0] win_1,
  output logic [7:0] win_2,
  output logic [7:0] win_3,
  output logic [7:0] win_4,
  output logic [7:0] win_5,
  output logic [7:0] win_6,
  output logic [7:0] win_7,
  output logic [7:0] win_8,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    win [9];
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_done;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  assign win_done = (row >= RW'(2)) && (col >= CW'(2));
  assign lb0_rd   = lb0[col];
  assign lb1_rd   = lb1[col];

  // Line buffers carry no reset; the row/col gating keeps stale entries out of valid windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= in_pixel;
        out_valid <= win_done;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign win_0 = win[0];
  assign win_1 = win[1];
  assign win_2 = win[2];
  assign win_3 = win[3];
  assign win_4 = win[4];
  assign win_5 = win[5];
  assign win_6 = win[6];
  assign win_7 = win[7];
  assign win_8 = win[8];

endmodule

// File: tb/tb_window_3x3_linebuffer.sv
// Bench for window_3x3_linebuffer: a 4x4 instance for directed scenarios and a default
// 8x8 instance for a random frame, both checked against a frame-array reference model.
module tb_window_3x3_linebuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [2];
  logic [7:0] in_pixel  [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       frame_done[2];
  logic [7:0] win [2][9];

  always #5 clk = ~clk;

  window_3x3_linebuffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_4x4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_pixel(in_pixel[0]), .in_ready(in_ready[0]),
    .win_0(win[0][0]), .win_1(win[0][1]), .win_2(win[0][2]), .win_3(win[0][3]), .win_4(win[0][4]),
    .win_5(win[0][5]), .win_6(win[0][6]), .win_7(win[0][7]), .win_8(win[0][8]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .frame_done(frame_done[0])
  );

  window_3x3_linebuffer dut_8x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_pixel(in_pixel[1]), .in_ready(in_ready[1]),
    .win_0(win[1][0]), .win_1(win[1][1]), .win_2(win[1][2]), .win_3(win[1][3]), .win_4(win[1][4]),
    .win_5(win[1][5]), .win_6(win[1][6]), .win_7(win[1][7]), .win_8(win[1][8]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .frame_done(frame_done[1])
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model: the frame as a 2D array, windows pending for the consumer, raster position
  logic [7:0]  frame [8][8];
  logic [71:0] exp_q [$];
  logic [71:0] seen  [$];
  int          mr = 0;
  int          mc = 0;
  bit          fd_exp = 1'b0;
  int          fd_seen = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] pack(input int k);
    return {win[k][0], win[k][1], win[k][2], win[k][3], win[k][4],
            win[k][5], win[k][6], win[k][7], win[k][8]};
  endfunction

  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w = '0;
    for (int rr = r - 2; rr <= r; rr++)
      for (int cc = c - 2; cc <= c; cc++)
        w = {w[63:0], frame[rr][cc]};
    return w;
  endfunction

  // window of a 4-wide frame whose pixels are base+index, top-left pixel index t
  function automatic logic [71:0] exp_win(input int t, input int base);
    logic [71:0] w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w = {w[63:0], 8'(base + t + rr * 4 + cc)};
    return w;
  endfunction

  // one clock cycle, entered and left at a falling edge
  task automatic cycle(input int k, input bit v, input logic [7:0] p, input bit ordy, output bit acc);
    int  dim;
    bit  exp_rdy;
    dim = (k == 1) ? 8 : 4;
    check("out_valid", 72'(out_valid[k]), 72'(exp_q.size() != 0));
    check("frame_done", 72'(frame_done[k]), 72'(fd_exp));
    if (frame_done[k]) fd_seen++;
    if (exp_q.size() != 0) check("window", pack(k), exp_q[0]);
    in_valid[k]  = v;
    in_pixel[k]  = p;
    out_ready[k] = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", 72'(in_ready[k]), 72'(exp_rdy));
    acc = v && exp_rdy;
    fd_exp = 1'b0;
    if (exp_q.size() != 0 && ordy) begin
      seen.push_back(pack(k));
      void'(exp_q.pop_front());
    end
    if (acc) begin
      frame[mr][mc] = p;
      if (mr >= 2 && mc >= 2) exp_q.push_back(model_win(mr, mc));
      if (mc == dim - 1) begin
        mc = 0;
        if (mr == dim - 1) begin
          mr = 0;
          fd_exp = 1'b1;
        end else mr++;
      end else mc++;
    end
    @(negedge clk);
  endtask

  task automatic feed(input int k, input logic [7:0] p, input bit rnd);
    bit acc = 1'b0;
    int tries = 0;
    bit v, ordy;
    while (!acc && tries < 200) begin
      v    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ordy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(k, v, p, ordy, acc);
      tries++;
    end
    if (!acc) check("feed_timeout", 72'(acc), 72'(1));
  endtask

  task automatic idle(input int k, input int n);
    bit acc;
    repeat (n) cycle(k, 1'b0, 8'd0, 1'b1, acc);
  endtask

  task automatic start_scn();
    seen.delete();
    fd_seen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", 72'(out_valid[k]), 72'(0));
      check("rst_frame_done", 72'(frame_done[k]), 72'(0));
      check("rst_in_ready", 72'(in_ready[k]), 72'(1));
      check("rst_win", pack(k), 72'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) out_ready[k] = 1'b1;
    exp_q.delete();
    mr = 0;
    mc = 0;
    fd_exp = 1'b0;
  endtask

  // the four windows of a 4x4 frame in order, for nf consecutive frames offset by 100
  task automatic check_seq(input string tag, input int nf);
    int tl [4] = '{0, 1, 4, 5};
    check({tag, "_count"}, 72'(seen.size()), 72'(4 * nf));
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < 4; i++)
        if (f * 4 + i < seen.size())
          check({tag, "_win"}, seen[f * 4 + i], exp_win(tl[i], f * 100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit acc;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_pixel[k]  = 8'd0;
      out_ready[k] = 1'b1;
    end
    @(negedge clk);
    do_reset();

    // frame order
    start_scn();
    for (int i = 0; i < 16; i++) feed(0, 8'(i), 1'b0);
    idle(0, 4);
    check_seq("order", 1);
    check("order_fd", 72'(fd_seen), 72'(1));

    // backpressure on the first window
    start_scn();
    for (int i = 0; i < 11; i++) feed(0, 8'(i), 1'b0);
    repeat (5) begin
      cycle(0, 1'b1, 8'd11, 1'b0, acc);
      check("bp_hold_win", pack(0), exp_win(0, 0));
      check("bp_hold_valid", 72'(out_valid[0]), 72'(1));
    end
    check("bp_no_consume", 72'(mc), 72'(3));
    for (int i = 11; i < 16; i++) feed(0, 8'(i), 1'b0);
    idle(0, 4);
    check_seq("bp", 1);

    // input bubbles
    start_scn();
    for (int i = 0; i < 16; i++) begin
      feed(0, 8'(i), 1'b0);
      cycle(0, 1'b0, 8'hEE, 1'b1, acc);
    end
    idle(0, 4);
    check_seq("bubble", 1);
    check("bubble_fd", 72'(fd_seen), 72'(1));

    // back-to-back frames
    start_scn();
    for (int i = 0; i < 16; i++) feed(0, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) feed(0, 8'(100 + i), 1'b0);
    idle(0, 4);
    check_seq("b2b", 2);
    check("b2b_fd", 72'(fd_seen), 72'(2));

    // reset mid-frame
    start_scn();
    for (int i = 0; i < 10; i++) feed(0, 8'(i), 1'b0);
    check("rstmid_pre_count", 72'(seen.size()), 72'(0));
    do_reset();
    start_scn();
    for (int i = 0; i < 16; i++) feed(0, 8'(i), 1'b0);
    idle(0, 4);
    check_seq("rstmid", 1);
    check("rstmid_fd", 72'(fd_seen), 72'(1));

    // default 8x8 with random pixels and random handshakes
    start_scn();
    for (int i = 0; i < 64; i++) feed(1, 8'($urandom_range(0, 255)), 1'b1);
    idle(1, 6);
    check("rand_count", 72'(seen.size()), 72'(36));
    check("rand_fd", 72'(fd_seen), 72'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
